// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM handshake and arbiter state types.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [2:0] {IDLE, IGRANT, DGRANT, HALTED, ERR} arbstate_t;
endpackage

// File: rtl/mem_arbiter_stats.sv
// mem_arbiter_stats: free-running grant and stall counters, wrapping modulo 2^32.
module mem_arbiter_stats
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  logic  dhit,
    input  logic  req,
    output word_t igrant_cnt,
    output word_t dgrant_cnt,
    output word_t stall_cnt
);
    always_ff @(posedge CLK) begin
        if (RST) begin
            igrant_cnt <= '0;
            dgrant_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            igrant_cnt <= igrant_cnt + word_t'(ihit);
            dgrant_cnt <= dgrant_cnt + word_t'(dhit);
            stall_cnt  <= stall_cnt + word_t'(req && !(ihit || dhit));
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between fetch and data with starvation bound, timeout and halt drain.
// Define MEM_ARBITER_STATS_EN to add igrant_cnt/dgrant_cnt/stall_cnt outputs.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      ihit,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dhit,
    output word_t     dload,
    input  logic      halt,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      halted,
`ifdef MEM_ARBITER_STATS_EN
    output word_t     igrant_cnt,
    output word_t     dgrant_cnt,
    output word_t     stall_cnt,
`endif
    output logic      arb_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WMAX = WW'(TIMEOUT);

    arbstate_t     state_q, state_d, arb_next;
    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          data_req, ilive, dlive, live, granted, done, arb;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wait_q   <= wait_d;
        end
    end

    // A grant is "live" only while its requester still holds the request.
    always_comb begin
        data_req = dREN | dWEN;
        ilive    = state_q == IGRANT && iREN;
        dlive    = state_q == DGRANT && data_req;
        live     = ilive | dlive;
        granted  = state_q == IGRANT || state_q == DGRANT;
        done     = live && ramstate == ACCESS;
        arb      = state_q == IDLE || done;
        arb_next = halt ? HALTED : (data_req && starve_q < SMAX) ? DGRANT : iREN ? IGRANT : IDLE;
        state_d  = arb ? arb_next : !granted ? state_q : !live ? IDLE :
                   (ramstate == ERROR || wait_q >= WMAX) ? ERR : state_q;
        wait_d   = arb ? '0 : (granted && wait_q < WMAX) ? wait_q + WW'(1) : wait_q;
        starve_d = !iREN ? '0 : !arb ? starve_q : arb_next == IGRANT ? '0 :
                   (arb_next == DGRANT && starve_q < SMAX) ? starve_q + SW'(1) : starve_q;
    end

    always_comb begin
        ihit     = ilive && ramstate == ACCESS;
        dhit     = dlive && ramstate == ACCESS;
        iload    = ihit ? ramload : '0;
        dload    = dhit ? ramload : '0;
        ramREN   = ilive | (dlive & ~dWEN);
        ramWEN   = dlive & dWEN;
        ramaddr  = state_q == IGRANT ? iaddr : state_q == DGRANT ? daddr : '0;
        ramstore = state_q == DGRANT ? dstore : '0;
        halted   = state_q == HALTED;
        arb_err  = state_q == ERR;
    end

`ifdef MEM_ARBITER_STATS_EN
    mem_arbiter_stats u_stats (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dhit       (dhit),
        .req        (iREN | data_req),
        .igrant_cnt (igrant_cnt),
        .dgrant_cnt (dgrant_cnt),
        .stall_cnt  (stall_cnt)
    );
`endif
endmodule
